// File: rtl/alu_op_sequencer.sv
// Control-side driver for the datapath ALU: issues one registered one-hot strobe per operation
// for a fixed settle window, then captures the 64-bit ALU result into Z_high/Z_low.
//
// state | meaning
// IDLE  | waiting for start; illegal opcodes are rejected with a one-cycle pulse
// EXEC  | selected strobe held high while the settle counter runs down to zero
// DONE  | Z holds the new result; done and busy high for one cycle
module alu_op_sequencer #(
    parameter int ALU_WAIT    = 1,
    parameter int MULDIV_WAIT = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [63:0] ALU_Out_64,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        MUL,
    output logic        DIV,
    output logic        NEG,
    output logic        NOT,
    output logic        IncPC,
    output logic [31:0] Z_high,
    output logic [31:0] Z_low,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int WMAX  = (ALU_WAIT > MULDIV_WAIT) ? ALU_WAIT : MULDIV_WAIT;
    localparam int CNT_W = (WMAX > 1) ? $clog2(WMAX) : 1;

    localparam logic [CNT_W-1:0] LOAD_ALU    = CNT_W'(ALU_WAIT - 1);
    localparam logic [CNT_W-1:0] LOAD_MULDIV = CNT_W'(MULDIV_WAIT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [13:0]      strobe_q;
    logic             illegal_q;
    logic             op_legal;
    logic             op_muldiv;

    assign op_legal  = (opcode <= 5'd13);
    assign op_muldiv = (opcode == 5'd9) || (opcode == 5'd10);

    // The one-hot strobe register doubles as the latched opcode for the whole EXEC window.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= S_IDLE;
            cnt       <= '0;
            strobe_q  <= '0;
            illegal_q <= 1'b0;
            Z_high    <= '0;
            Z_low     <= '0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op_legal) begin
                            strobe_q <= 14'd1 << opcode;
                            cnt      <= op_muldiv ? LOAD_MULDIV : LOAD_ALU;
                            state    <= S_EXEC;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        Z_high   <= ALU_Out_64[63:32];
                        Z_low    <= ALU_Out_64[31:0];
                        strobe_q <= '0;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    strobe_q <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign ADD   = strobe_q[0];
    assign SUB   = strobe_q[1];
    assign AND   = strobe_q[2];
    assign OR    = strobe_q[3];
    assign SHR   = strobe_q[4];
    assign SHRA  = strobe_q[5];
    assign SHL   = strobe_q[6];
    assign ROR   = strobe_q[7];
    assign ROL   = strobe_q[8];
    assign MUL   = strobe_q[9];
    assign DIV   = strobe_q[10];
    assign NEG   = strobe_q[11];
    assign NOT   = strobe_q[12];
    assign IncPC = strobe_q[13];

    assign busy    = (state == S_EXEC) || (state == S_DONE);
    assign done    = (state == S_DONE);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU driven by the DUT strobes.
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [63:0] ALU_Out_64;
    logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT, IncPC;
    logic [31:0] Z_high, Z_low;
    logic        busy, done, illegal;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [13:0] strobes;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_op_sequencer #(.ALU_WAIT(1), .MULDIV_WAIT(4)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode), .ALU_Out_64(ALU_Out_64),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT), .IncPC(IncPC),
        .Z_high(Z_high), .Z_low(Z_low), .busy(busy), .done(done), .illegal(illegal)
    );

    assign strobes = {IncPC, NOT, NEG, DIV, MUL, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD};

    // Stand-in ALU; drives a marker pattern when no strobe is active so a mistimed capture shows up.
    always_comb begin
        ALU_Out_64 = 64'hA5A5_A5A5_5A5A_5A5A;
        case (strobes)
            14'h0001: ALU_Out_64 = {32'd0, a + b};
            14'h0002: ALU_Out_64 = {32'd0, a - b};
            14'h0004: ALU_Out_64 = {32'd0, a & b};
            14'h0008: ALU_Out_64 = {32'd0, a | b};
            14'h0010: ALU_Out_64 = {32'd0, a >> b[4:0]};
            14'h0020: ALU_Out_64 = {32'd0, $signed(a) >>> b[4:0]};
            14'h0040: ALU_Out_64 = {32'd0, a << b[4:0]};
            14'h0080: ALU_Out_64 = {32'd0, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
            14'h0100: ALU_Out_64 = {32'd0, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
            14'h0200: ALU_Out_64 = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            14'h0400: ALU_Out_64 = (b != 0) ? {a % b, a / b} : 64'd0;
            14'h0800: ALU_Out_64 = {32'd0, -b};
            14'h1000: ALU_Out_64 = {32'd0, ~b};
            14'h2000: ALU_Out_64 = {32'd0, a + 32'd1};
            default:  ALU_Out_64 = 64'hA5A5_A5A5_5A5A_5A5A;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge; one-hot checked every cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        chk("onehot", 64'($countones(strobes) <= 1), 64'd1);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_strobes", 64'(strobes), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_z", {Z_high, Z_low}, 64'd0);
        clear = 1'b1;
        tick();

        // 1: ADD 5+3, W=1
        a = 32'd5; b = 32'd3; opcode = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("add_strobe_t1", 64'(strobes), 64'h0001);
        chk("add_busy_t1", 64'(busy), 64'd1);
        chk("add_done_t1", 64'(done), 64'd0);
        tick();
        chk("add_strobe_t2", 64'(strobes), 64'd0);
        chk("add_done_t2", 64'(done), 64'd1);
        chk("add_busy_t2", 64'(busy), 64'd1);
        chk("add_z", {Z_high, Z_low}, 64'h0000_0000_0000_0008);
        tick();
        chk("add_done_t3", 64'(done), 64'd0);
        chk("add_busy_t3", 64'(busy), 64'd0);

        // 2: MUL -3 * 7, W=4
        a = 32'hFFFF_FFFD; b = 32'd7; opcode = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("mul_strobe_t%0d", i), 64'(strobes), 64'h0200);
            chk($sformatf("mul_done_t%0d", i), 64'(done), 64'd0);
            tick();
        end
        chk("mul_done_t5", 64'(done), 64'd1);
        chk("mul_z", {Z_high, Z_low}, 64'hFFFF_FFFF_FFFF_FFEB);
        tick();

        // 3: DIV 17/5 with an ignored start of ADD at T+2
        a = 32'd17; b = 32'd5; opcode = 5'd10; start = 1'b1;
        tick();
        start = 1'b0;
        chk("div_strobe_t1", 64'(strobes), 64'h0400);
        tick();
        start = 1'b1; opcode = 5'd0;
        chk("div_strobe_t2", 64'(strobes), 64'h0400);
        tick();
        start = 1'b0;
        chk("div_strobe_t3", 64'(strobes), 64'h0400);
        tick();
        chk("div_strobe_t4", 64'(strobes), 64'h0400);
        tick();
        chk("div_done_t5", 64'(done), 64'd1);
        chk("div_strobe_t5", 64'(strobes), 64'd0);
        chk("div_z", {Z_high, Z_low}, 64'h0000_0002_0000_0003);
        tick();
        chk("div_no_add_strobe", 64'(strobes), 64'd0);
        chk("div_idle_busy", 64'(busy), 64'd0);

        // 4: illegal opcode
        opcode = 5'h1F; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_pulse", 64'(illegal), 64'd1);
        chk("ill_strobes", 64'(strobes), 64'd0);
        chk("ill_busy", 64'(busy), 64'd0);
        chk("ill_z_kept", {Z_high, Z_low}, 64'h0000_0002_0000_0003);
        tick();
        chk("ill_pulse_end", 64'(illegal), 64'd0);
        opcode = 5'd14; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill14_pulse", 64'(illegal), 64'd1);
        chk("ill14_busy", 64'(busy), 64'd0);
        tick();

        // 5: MUL aborted by clear at the edge ending T+2
        a = 32'd2; b = 32'd3; opcode = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_strobe_t1", 64'(strobes), 64'h0200);
        tick();
        clear = 1'b0;
        tick();
        chk("abort_strobes", 64'(strobes), 64'd0);
        chk("abort_z", {Z_high, Z_low}, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_no_done_%0d", i), 64'(done), 64'd0);
            chk($sformatf("abort_z_%0d", i), {Z_high, Z_low}, 64'd0);
        end

        // 6: back-to-back NEG then NOT at the first free cycle
        a = 32'd0; b = 32'd1; opcode = 5'd11; start = 1'b1;
        tick();
        start = 1'b0;
        chk("neg_strobe", 64'(strobes), 64'h0800);
        tick();
        chk("neg_done", 64'(done), 64'd1);
        chk("neg_z", {Z_high, Z_low}, 64'h0000_0000_FFFF_FFFF);
        b = 32'd0; opcode = 5'd12; start = 1'b1;
        tick();
        chk("b2b_idle_busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        chk("not_strobe", 64'(strobes), 64'h1000);
        chk("not_busy", 64'(busy), 64'd1);
        tick();
        chk("not_done", 64'(done), 64'd1);
        chk("not_z", {Z_high, Z_low}, 64'h0000_0000_FFFF_FFFF);
        tick();

        // Extra single-cycle ops: SHRA and IncPC
        a = 32'h8000_0010; b = 32'd4; opcode = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("shra_strobe", 64'(strobes), 64'h0020);
        tick();
        chk("shra_z", {Z_high, Z_low}, 64'h0000_0000_F800_0001);
        tick();
        a = 32'h0000_00FF; opcode = 5'd13; start = 1'b1;
        tick();
        start = 1'b0;
        chk("incpc_strobe", 64'(strobes), 64'h2000);
        tick();
        chk("incpc_z", {Z_high, Z_low}, 64'h0000_0000_0000_0100);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
